perf_counter_bank: RTL and testbench

- Parametrised bank of hardware performance counters, memory-mapped on the CPU's MMIO data path.
- Generalises the fixed cycle and instruction counters into N event channels:
  - channel 0 = cycles, channel 1 = retired instructions by convention
  - configurable counter width up to 64 bits
  - wrap or saturate mode, sticky overflow flags with interrupt
  - global freeze, per-channel enable
  - atomic 64-bit reads through a high-word shadow latch
- Software reads the counters directly, with no testbench hierarchy peeking.

---
 rtl/perf_pkg.sv | 15 +
 rtl/perf_counter_chan.sv | 62 ++++++
 rtl/perf_counter_bank.sv | 120 ++++++++++++
 tb/tb_perf_counter_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared register map and control-bit definitions for the performance counter bank.
package perf_pkg;

  localparam int MAX_EVENTS = 16;

  localparam logic [31:0] CTRL_OFF       = 32'h00;
  localparam logic [31:0] EN_MASK_OFF    = 32'h04;
  localparam logic [31:0] OVF_OFF        = 32'h08;
  localparam logic [31:0] OVF_IRQ_EN_OFF = 32'h0C;
  localparam logic [31:0] CNT_BASE       = 32'h40;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_CLEAR_BIT = 1;

endpackage

// File: rtl/perf_counter_chan.sv
// One counter channel: the counter, its high-word read shadow and overflow detection.
module perf_counter_chan #(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 clear_i,
  input  logic                 wr_lo_i,
  input  logic                 wr_hi_i,
  input  logic [31:0]          wdata_i,
  input  logic                 latch_hi_i,
  output logic [CNT_WIDTH-1:0] value_o,
  output logic [31:0]          hi_shadow_o,
  output logic                 ovf_pulse_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [CNT_WIDTH:0]   sum;
  logic [63:0]          cnt_ext;
  logic [63:0]          wr_val;

  always_comb begin
    cnt_ext     = 64'(cnt_q);
    sum         = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);
    wr_val      = wr_lo_i ? ((cnt_ext & 64'hFFFF_FFFF_0000_0000) | 64'(wdata_i))
                          : ((cnt_ext & 64'h0000_0000_FFFF_FFFF) | {wdata_i, 32'h0});
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    ovf_pulse_o = 1'b0;
    if (clear_i) begin
      cnt_d    = '0;
      shadow_d = '0;
    end else begin
      // A software write takes the cycle; a coincident event is dropped.
      if (wr_lo_i || wr_hi_i) begin
        cnt_d = CNT_WIDTH'(wr_val);
      end else if (inc_i) begin
        ovf_pulse_o = sum[CNT_WIDTH];
        cnt_d       = (sum[CNT_WIDTH] && SATURATE) ? cnt_q : sum[CNT_WIDTH-1:0];
      end
      // Shadow captures the same pre-edge value whose low word is being returned.
      if (latch_hi_i) shadow_d = cnt_ext[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign value_o     = cnt_q;
  assign hi_shadow_o = shadow_q;

endmodule

// File: rtl/perf_counter_bank.sv
// MMIO-mapped bank of event counters with global run, per-channel enable and overflow IRQ.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int SATURATE   = 0,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  mmio_we,
  input  logic                  mmio_re,
  input  logic [ADDR_WIDTH-1:0] mmio_addr,
  input  logic [31:0]           mmio_wdata,
  output logic [31:0]           mmio_rdata,
  output logic                  ovf_irq
);

  localparam logic [31:0] CNT_END = CNT_BASE + 32'(8 * MAX_EVENTS);

  logic                  run_q, run_d;
  logic [NUM_EVENTS-1:0] en_mask_q, en_mask_d;
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;
  logic [NUM_EVENTS-1:0] irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0] addr_w, cnt_idx;
  logic        cnt_hit, is_hi, clear;
  logic [NUM_EVENTS-1:0] cnt_sel, inc, wr_lo, wr_hi, latch_hi, ovf_pulse;
  logic [CNT_WIDTH-1:0]  cnt_val   [NUM_EVENTS];
  logic [31:0]           cnt_lo    [NUM_EVENTS];
  logic [31:0]           hi_shadow [NUM_EVENTS];

  assign addr_w  = 32'(mmio_addr) & ~32'h3;
  assign cnt_hit = (addr_w >= CNT_BASE) && (addr_w < CNT_END);
  assign cnt_idx = (addr_w - CNT_BASE) >> 3;
  assign is_hi   = addr_w[2];
  assign clear   = mmio_we && (addr_w == CTRL_OFF) && mmio_wdata[CTRL_CLEAR_BIT];

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_chan
    assign cnt_sel[g]  = cnt_hit && (cnt_idx == 32'(g));
    assign inc[g]      = run_q & en_mask_q[g] & event_in[g];
    assign wr_lo[g]    = mmio_we & cnt_sel[g] & ~is_hi;
    assign wr_hi[g]    = mmio_we & cnt_sel[g] & is_hi;
    assign latch_hi[g] = mmio_re & cnt_sel[g] & ~is_hi;
    assign cnt_lo[g]   = 32'(cnt_val[g]);

    perf_counter_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE != 0)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (inc[g]),
      .clear_i     (clear),
      .wr_lo_i     (wr_lo[g]),
      .wr_hi_i     (wr_hi[g]),
      .wdata_i     (mmio_wdata),
      .latch_hi_i  (latch_hi[g]),
      .value_o     (cnt_val[g]),
      .hi_shadow_o (hi_shadow[g]),
      .ovf_pulse_o (ovf_pulse[g])
    );
  end

  always_comb begin
    run_d    = run_q;
    en_mask_d = en_mask_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (mmio_we) begin
      if (addr_w == CTRL_OFF)       run_d     = mmio_wdata[CTRL_RUN_BIT];
      if (addr_w == EN_MASK_OFF)    en_mask_d = mmio_wdata[NUM_EVENTS-1:0];
      if (addr_w == OVF_IRQ_EN_OFF) irq_en_d  = mmio_wdata[NUM_EVENTS-1:0];
      if (addr_w == OVF_OFF)        ovf_d     = ovf_q & ~mmio_wdata[NUM_EVENTS-1:0];
    end
    // A new overflow beats a same-cycle clear of that flag.
    ovf_d = ovf_d | ovf_pulse;
    irq_d = |(ovf_q & irq_en_q);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (mmio_re) begin
      rdata_d = '0;
      if (addr_w == CTRL_OFF)       rdata_d = {31'h0, run_q};
      if (addr_w == EN_MASK_OFF)    rdata_d = 32'(en_mask_q);
      if (addr_w == OVF_OFF)        rdata_d = 32'(ovf_q);
      if (addr_w == OVF_IRQ_EN_OFF) rdata_d = 32'(irq_en_q);
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (cnt_sel[i]) rdata_d = is_hi ? hi_shadow[i] : cnt_lo[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= 1'b0;
      en_mask_q <= '1;
      ovf_q     <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      run_q     <= run_d;
      en_mask_q <= en_mask_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mmio_rdata = rdata_q;
  assign ovf_irq    = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three configurations share one MMIO/event stimulus stream.
module tb_perf_counter_bank;

  localparam int D64 = 0;
  localparam int D8W = 1;
  localparam int D8S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  event_in = '0;
  logic        mmio_we = 1'b0;
  logic        mmio_re = 1'b0;
  logic [7:0]  mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic [31:0] rd64, rd8w, rd8s;
  logic        irq64, irq8w, irq8s;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       tag_q[$];
  logic        re_d = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(64), .SATURATE(0), .ADDR_WIDTH(8)) u_d64 (
    .clk(clk), .rst(rst), .event_in(event_in), .mmio_we(mmio_we), .mmio_re(mmio_re),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(rd64), .ovf_irq(irq64));

  perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(8), .SATURATE(0), .ADDR_WIDTH(8)) u_d8w (
    .clk(clk), .rst(rst), .event_in(event_in), .mmio_we(mmio_we), .mmio_re(mmio_re),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(rd8w), .ovf_irq(irq8w));

  perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(8), .SATURATE(1), .ADDR_WIDTH(8)) u_d8s (
    .clk(clk), .rst(rst), .event_in(event_in), .mmio_we(mmio_we), .mmio_re(mmio_re),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(rd8s), .ovf_irq(irq8s));

  // clock / reset
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) re_d <= mmio_re;

  // monitor: one response per read, one cycle after the strobe
  always @(negedge clk) begin
    logic [31:0] e, got;
    int          s;
    string       t;
    if (re_d) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: got response %h expected none", rd64);
      end else begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        t = tag_q.pop_front();
        got = (s == D64) ? rd64 : ((s == D8W) ? rd8w : rd8s);
        if (got !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", t, got, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; mmio_we = 1'b0; mmio_re = 1'b0; event_in = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic mmio_write(input logic [7:0] a, input logic [31:0] d);
    mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
    @(negedge clk);
    mmio_we = 1'b0;
  endtask

  task automatic mmio_read(input logic [7:0] a, input logic [31:0] e, input int s, input string t);
    mmio_re = 1'b1; mmio_addr = a;
    exp_q.push_back(e); sel_q.push_back(s); tag_q.push_back(t);
    @(negedge clk);
    mmio_re = 1'b0;
  endtask

  task automatic mmio_rw(input logic [7:0] a, input logic [31:0] d, input logic [31:0] e,
                         input int s, input string t);
    mmio_we = 1'b1; mmio_re = 1'b1; mmio_addr = a; mmio_wdata = d;
    exp_q.push_back(e); sel_q.push_back(s); tag_q.push_back(t);
    @(negedge clk);
    mmio_we = 1'b0; mmio_re = 1'b0;
  endtask

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] e);
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, got, e);
    end
  endtask

  task automatic read_reset_values(input string t);
    mmio_read(8'h00, 32'h0, D64, {t, "_ctrl"});
    mmio_read(8'h04, 32'hF, D64, {t, "_en_mask"});
    mmio_read(8'h08, 32'h0, D64, {t, "_ovf"});
    mmio_read(8'h0C, 32'h0, D64, {t, "_irq_en"});
    for (int i = 0; i < 4; i++) begin
      mmio_read(8'(8'h44 + 8 * i), 32'h0, D64, $sformatf("%s_hi%0d", t, i));
      mmio_read(8'(8'h40 + 8 * i), 32'h0, D64, $sformatf("%s_lo%0d", t, i));
    end
    mmio_read(8'h04, 32'hF, D8S, {t, "_en_mask_8s"});
  endtask

  initial begin
    // 1: reset values, unmapped accesses
    reset_dut();
    check("rst_rdata", rd64, 32'h0);
    check("rst_irq", {29'h0, irq64, irq8w, irq8s}, 32'h0);
    read_reset_values("t1");
    mmio_write(8'h10, 32'hFFFF_FFFF);
    mmio_write(8'h70, 32'hFFFF_FFFF);
    mmio_read(8'h10, 32'h0, D64, "t1_unmapped");
    mmio_read(8'h70, 32'h0, D64, "t1_out_of_range");
    mmio_read(8'h00, 32'h0, D64, "t1_ctrl_after_unmapped");

    // 2: counting, alternate events, rdata hold, EN_MASK gating
    mmio_write(8'h00, 32'h1);
    for (int k = 0; k < 100; k++) begin
      event_in = {2'b00, (k % 2 == 0), 1'b1};
      @(negedge clk);
    end
    event_in = '0;
    mmio_read(8'h40, 32'd100, D64, "t2_cnt0");
    mmio_read(8'h48, 32'd50, D64, "t2_cnt1");
    tick(2);
    check("t2_rdata_hold", rd64, 32'd50);
    mmio_write(8'h04, 32'h1);
    event_in = 4'h3;
    tick(10);
    event_in = '0;
    mmio_read(8'h40, 32'd110, D64, "t2_cnt0_masked");
    mmio_read(8'h48, 32'd50, D64, "t2_cnt1_frozen");
    mmio_read(8'h44, 32'h0, D64, "t2_hi0");
    mmio_read(8'h04, 32'h1, D64, "t2_en_mask");

    // 3: 8-bit wrap overflow and IRQ timing
    reset_dut();
    mmio_write(8'h40, 32'hFF);
    mmio_write(8'h0C, 32'h1);
    mmio_write(8'h00, 32'h1);
    event_in = 4'h1;
    @(negedge clk);
    event_in = '0;
    check("t3_irq_not_yet", {31'h0, irq8w}, 32'h0);
    @(negedge clk);
    check("t3_irq_rise_8w", {31'h0, irq8w}, 32'h1);
    check("t3_irq_rise_8s", {31'h0, irq8s}, 32'h1);
    check("t3_irq_64_quiet", {31'h0, irq64}, 32'h0);
    mmio_read(8'h40, 32'h00, D8W, "t3_wrap_cnt");
    mmio_read(8'h40, 32'hFF, D8S, "t3_sat_cnt");
    mmio_read(8'h44, 32'h0, D8W, "t3_hi_narrow");
    mmio_read(8'h40, 32'h100, D64, "t3_wide_cnt");
    mmio_read(8'h08, 32'h1, D8W, "t3_ovf_set");
    mmio_read(8'h08, 32'h0, D64, "t3_ovf_wide");
    mmio_write(8'h08, 32'h1);
    mmio_read(8'h08, 32'h0, D8W, "t3_ovf_w1c");
    check("t3_irq_fall", {31'h0, irq8w}, 32'h0);

    // 4: saturate, multi-event, set-beats-W1C
    reset_dut();
    mmio_write(8'h40, 32'hFF);
    mmio_write(8'h00, 32'h1);
    event_in = 4'h1;
    tick(3);
    event_in = '0;
    mmio_read(8'h40, 32'hFF, D8S, "t4_sat_hold");
    mmio_read(8'h08, 32'h1, D8S, "t4_sat_ovf");
    mmio_read(8'h40, 32'h02, D8W, "t4_wrap_3ev");
    mmio_read(8'h08, 32'h1, D8W, "t4_wrap_ovf");
    event_in = 4'h1;
    mmio_write(8'h08, 32'h1);
    event_in = '0;
    mmio_read(8'h08, 32'h1, D8S, "t4_set_beats_w1c");
    mmio_read(8'h08, 32'h0, D8W, "t4_w1c_no_set");
    mmio_read(8'h40, 32'h03, D8W, "t4_wrap_cnt");

    // 5: 64-bit atomic reads through the shadow
    reset_dut();
    mmio_write(8'h40, 32'hFFFF_FFFF);
    mmio_write(8'h44, 32'h1);
    mmio_read(8'h44, 32'h0, D64, "t5_hi_before_lo");
    event_in = 4'h1;
    mmio_write(8'h00, 32'h1);
    mmio_read(8'h40, 32'hFFFF_FFFF, D64, "t5_lo_first");
    tick(1);
    mmio_read(8'h44, 32'h1, D64, "t5_hi_shadow");
    mmio_read(8'h40, 32'h2, D64, "t5_lo_second");
    mmio_read(8'h44, 32'h2, D64, "t5_hi_second");
    event_in = '0;

    // 6: clear priority, write-beats-event, read-before-write, mid-run reset
    reset_dut();
    mmio_write(8'h5C, 32'h5);
    mmio_write(8'h00, 32'h1);
    event_in = 4'hF;
    tick(5);
    event_in = '0;
    mmio_read(8'h58, 32'h5, D64, "t6_lo3");
    mmio_read(8'h5C, 32'h5, D64, "t6_hi3");
    mmio_read(8'h40, 32'h5, D64, "t6_lo0");
    event_in = 4'hF;
    mmio_write(8'h00, 32'h3);
    event_in = '0;
    mmio_read(8'h5C, 32'h0, D64, "t6_shadow_cleared");
    for (int i = 0; i < 4; i++)
      mmio_read(8'(8'h40 + 8 * i), 32'h0, D64, $sformatf("t6_cleared_lo%0d", i));
    mmio_read(8'h00, 32'h1, D64, "t6_run_kept");
    event_in = 4'h4;
    mmio_write(8'h50, 32'h1234);
    event_in = '0;
    mmio_read(8'h50, 32'h1234, D64, "t6_write_wins");
    mmio_read(8'h54, 32'h0, D64, "t6_write_hi");
    mmio_rw(8'h04, 32'h5, 32'hF, D64, "t6_rw_old");
    mmio_read(8'h04, 32'h5, D64, "t6_rw_new");
    event_in = 4'hF;
    tick(3);
    rst = 1'b1; mmio_we = 1'b1; mmio_addr = 8'h04; mmio_wdata = 32'h0;
    @(negedge clk);
    rst = 1'b0; mmio_we = 1'b0; event_in = '0;
    check("t6_rst_rdata", rd64, 32'h0);
    read_reset_values("t6_rst");

    // final report
    tick(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
